// File: rtl/fwd_hazard_ctrl.sv
// Execute-stage operand forwarding, load-use hazard detection and cache-miss wait FSM.
// Optional performance counters are built in when HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl #(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MISS_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*5-1:0]    src_reg,
  input  logic                    valid_m,
  input  logic                    load_m,
  input  logic [4:0]              dest_m,
  input  logic [4:0]              dest_w,
  input  logic [XLEN-1:0]         data_m,
  input  logic [XLEN-1:0]         data_w,
  input  logic                    valid_w,
  input  logic                    mem_busy,
  input  logic                    mem_done,
  input  logic                    flush,
  output logic [NUM_SRC-1:0]      fwd,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic                    stall,
  output logic                    miss_pend,
  output logic                    miss_timeout,
  output logic [31:0]             ld_use_cnt,
  output logic [31:0]             miss_cyc_cnt
);

  typedef enum logic {
    IDLE,
    MISS_WAIT
  } state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(MISS_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        miss_pend_q, miss_pend_d;
  logic        miss_timeout_q, miss_timeout_d;
  logic        ld_hazard;
  logic        miss_entry;

  // Memory stage is checked first so a younger result always shadows writeback.
  always_comb begin
    fwd       = '0;
    fwd_data  = '0;
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && !flush) begin
        if (valid_m && (dest_m != 5'd0) && (src_reg[5*i +: 5] == dest_m)) begin
          fwd[i]                   = !load_m;
          fwd_data[XLEN*i +: XLEN] = data_m;
          if (load_m) begin
            ld_hazard = 1'b1;
          end
        end else if (valid_w && (dest_w != 5'd0) && (src_reg[5*i +: 5] == dest_w)) begin
          fwd[i]                   = 1'b1;
          fwd_data[XLEN*i +: XLEN] = data_w;
        end
      end
    end
  end

  assign miss_entry = valid_m && load_m && mem_busy && !mem_done;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    miss_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_entry) begin
          state_d    = MISS_WAIT;
          wait_cnt_d = '0;
        end
      end
      MISS_WAIT: begin
        if (mem_done) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_LIM) begin
          state_d        = IDLE;
          wait_cnt_d     = '0;
          miss_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
    miss_pend_d = (state_d == MISS_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      miss_pend_q    <= 1'b0;
      miss_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      miss_pend_q    <= miss_pend_d;
      miss_timeout_q <= miss_timeout_d;
    end
  end

  assign stall        = ld_hazard || (state_q == MISS_WAIT) || ((state_q == IDLE) && miss_entry);
  assign miss_pend    = miss_pend_q;
  assign miss_timeout = miss_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] ld_use_cnt_q, ld_use_cnt_d;
  logic [31:0] miss_cyc_cnt_q, miss_cyc_cnt_d;

  always_comb begin
    ld_use_cnt_d   = ld_use_cnt_q;
    miss_cyc_cnt_d = miss_cyc_cnt_q;
    if (ld_hazard && (ld_use_cnt_q != '1)) begin
      ld_use_cnt_d = ld_use_cnt_q + 32'd1;
    end
    if ((state_q == MISS_WAIT) && (miss_cyc_cnt_q != '1)) begin
      miss_cyc_cnt_d = miss_cyc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_use_cnt_q   <= '0;
      miss_cyc_cnt_q <= '0;
    end else begin
      ld_use_cnt_q   <= ld_use_cnt_d;
      miss_cyc_cnt_q <= miss_cyc_cnt_d;
    end
  end

  assign ld_use_cnt   = ld_use_cnt_q;
  assign miss_cyc_cnt = miss_cyc_cnt_q;
`else
  assign ld_use_cnt   = '0;
  assign miss_cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl; a second instance with MISS_TIMEOUT=3
// shares all inputs so the abort path can be observed alongside the default build.
module tb_fwd_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  src_valid;
  logic [9:0]  src_reg;
  logic        valid_m, load_m, valid_w, mem_busy, mem_done, flush;
  logic [4:0]  dest_m, dest_w;
  logic [31:0] data_m, data_w;

  logic [1:0]  fwd, fwd1;
  logic [63:0] fwd_data, fwd_data1;
  logic        stall, stall1;
  logic        miss_pend, miss_pend1;
  logic        miss_timeout, miss_timeout1;
  logic [31:0] ld_use_cnt, ld_use_cnt1, miss_cyc_cnt, miss_cyc_cnt1;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.NUM_SRC(2), .XLEN(32), .MISS_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_reg(src_reg),
    .valid_m(valid_m), .load_m(load_m), .dest_m(dest_m), .dest_w(dest_w),
    .data_m(data_m), .data_w(data_w), .valid_w(valid_w), .mem_busy(mem_busy),
    .mem_done(mem_done), .flush(flush), .fwd(fwd), .fwd_data(fwd_data),
    .stall(stall), .miss_pend(miss_pend), .miss_timeout(miss_timeout),
    .ld_use_cnt(ld_use_cnt), .miss_cyc_cnt(miss_cyc_cnt)
  );

  fwd_hazard_ctrl #(.NUM_SRC(2), .XLEN(32), .MISS_TIMEOUT(3)) dut_t3 (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_reg(src_reg),
    .valid_m(valid_m), .load_m(load_m), .dest_m(dest_m), .dest_w(dest_w),
    .data_m(data_m), .data_w(data_w), .valid_w(valid_w), .mem_busy(mem_busy),
    .mem_done(mem_done), .flush(flush), .fwd(fwd1), .fwd_data(fwd_data1),
    .stall(stall1), .miss_pend(miss_pend1), .miss_timeout(miss_timeout1),
    .ld_use_cnt(ld_use_cnt1), .miss_cyc_cnt(miss_cyc_cnt1)
  );

  typedef struct {
    string       tag;
    logic [1:0]  fwd;
    logic [63:0] data;
    logic        stall;
    logic        pend;
    logic        to;
    logic        t1_pend;
    logic        t1_to;
    logic [31:0] ld;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic clear_in();
    src_valid = '0; src_reg = '0; valid_m = 1'b0; load_m = 1'b0; valid_w = 1'b0;
    mem_busy = 1'b0; mem_done = 1'b0; flush = 1'b0; dest_m = '0; dest_w = '0;
    data_m = '0; data_w = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] f, input logic [63:0] d,
                            input logic st, input logic pend, input logic to,
                            input logic t1p, input logic t1t,
                            input int unsigned ldn, input int unsigned mcn);
    exp_t e;
    e.tag = tag; e.fwd = f; e.data = d; e.stall = st; e.pend = pend; e.to = to;
    e.t1_pend = t1p; e.t1_to = t1t;
    e.ld = PERF ? 32'(ldn) : 32'd0;
    e.mc = PERF ? 32'(mcn) : 32'd0;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string field, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, "fwd",          64'(fwd),           64'(e.fwd));
    chk(e.tag, "fwd_data",     fwd_data,           e.data);
    chk(e.tag, "stall",        64'(stall),         64'(e.stall));
    chk(e.tag, "miss_pend",    64'(miss_pend),     64'(e.pend));
    chk(e.tag, "miss_timeout", 64'(miss_timeout),  64'(e.to));
    chk(e.tag, "t3_miss_pend", 64'(miss_pend1),    64'(e.t1_pend));
    chk(e.tag, "t3_timeout",   64'(miss_timeout1), 64'(e.t1_to));
    chk(e.tag, "ld_use_cnt",   64'(ld_use_cnt),    64'(e.ld));
    chk(e.tag, "miss_cyc_cnt", 64'(miss_cyc_cnt),  64'(e.mc));
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    expect_out("reset", 2'b00, 64'h0, 0, 0, 0, 0, 0, 0, 0); check_out();

    // Forwarding patterns
    cyc(); rst_n = 1'b1;
    src_valid = 2'b01; src_reg = 10'd5; valid_m = 1; load_m = 0; dest_m = 5;
    data_m = 32'hAAAA0001; valid_w = 1; dest_w = 5; data_w = 32'h1;
    expect_out("m_over_w", 2'b01, 64'h0000_0000_AAAA_0001, 0, 0, 0, 0, 0, 0, 0); check_out();

    cyc(); src_valid = 2'b11; src_reg = {5'd9, 5'd5}; dest_w = 9;
    expect_out("two_src", 2'b11, {32'h1, 32'hAAAA0001}, 0, 0, 0, 0, 0, 0, 0); check_out();

    cyc(); flush = 1;
    expect_out("flush", 2'b00, 64'h0, 0, 0, 0, 0, 0, 0, 0); check_out();

    cyc(); clear_in();
    src_valid = 2'b10; src_reg = {5'd7, 5'd0}; valid_m = 1; load_m = 1; dest_m = 7;
    data_m = 32'h12345678; valid_w = 1; dest_w = 7; data_w = 32'h55;
    expect_out("load_use", 2'b00, {32'h12345678, 32'h0}, 1, 0, 0, 0, 0, 0, 0); check_out();

    cyc(); flush = 1;
    expect_out("load_use_flush", 2'b00, 64'h0, 0, 0, 0, 0, 0, 1, 0); check_out();

    cyc(); clear_in();
    expect_out("quiet", 2'b00, 64'h0, 0, 0, 0, 0, 0, 1, 0); check_out();

    cyc(); src_valid = 2'b11; src_reg = '0; valid_m = 1; load_m = 1; dest_m = 0;
    data_m = 32'hFFFF; valid_w = 1; dest_w = 0; data_w = 32'hEEEE;
    expect_out("reg0", 2'b00, 64'h0, 0, 0, 0, 0, 0, 1, 0); check_out();

    // Miss resolved by mem_done after four busy cycles
    cyc(); clear_in(); valid_m = 1; load_m = 1; dest_m = 3; data_m = 32'hDEAD0003; mem_busy = 1;
    expect_out("miss_a", 2'b00, 64'h0, 1, 0, 0, 0, 0, 1, 0); check_out();
    cyc();
    expect_out("miss_b", 2'b00, 64'h0, 1, 1, 0, 1, 0, 1, 0); check_out();
    cyc(); flush = 1; src_valid = 2'b01; src_reg = 10'd3;
    expect_out("miss_c_flush", 2'b00, 64'h0, 1, 1, 0, 1, 0, 1, 1); check_out();
    cyc(); flush = 0;
    expect_out("miss_d_lduse", 2'b00, {32'h0, 32'hDEAD0003}, 1, 1, 0, 1, 0, 1, 2); check_out();
    cyc(); clear_in(); mem_done = 1;
    expect_out("miss_e_done", 2'b00, 64'h0, 1, 1, 0, 1, 0, 2, 3); check_out();
    cyc(); clear_in();
    expect_out("miss_f_idle", 2'b00, 64'h0, 0, 0, 0, 0, 0, 2, 4); check_out();

    // Timeout on the MISS_TIMEOUT=3 instance, default instance keeps waiting
    cyc(); valid_m = 1; load_m = 1; dest_m = 3; mem_busy = 1;
    expect_out("to_g", 2'b00, 64'h0, 1, 0, 0, 0, 0, 2, 4); check_out();
    cyc();
    expect_out("to_h", 2'b00, 64'h0, 1, 1, 0, 1, 0, 2, 4); check_out();
    cyc();
    expect_out("to_i", 2'b00, 64'h0, 1, 1, 0, 1, 0, 2, 5); check_out();
    cyc();
    expect_out("to_j", 2'b00, 64'h0, 1, 1, 0, 1, 0, 2, 6); check_out();
    cyc();
    expect_out("to_k", 2'b00, 64'h0, 1, 1, 0, 1, 0, 2, 7); check_out();
    cyc(); valid_m = 0;
    expect_out("to_l_pulse", 2'b00, 64'h0, 1, 1, 0, 0, 1, 2, 8); check_out();
    cyc(); mem_busy = 0; mem_done = 1;
    expect_out("to_m_once", 2'b00, 64'h0, 1, 1, 0, 0, 0, 2, 9); check_out();

    // Reset in the second MISS_WAIT cycle
    cyc(); clear_in(); valid_m = 1; load_m = 1; dest_m = 3; mem_busy = 1;
    expect_out("rst_n_entry", 2'b00, 64'h0, 1, 0, 0, 0, 0, 2, 10); check_out();
    cyc();
    expect_out("rst_o_wait1", 2'b00, 64'h0, 1, 1, 0, 1, 0, 2, 10); check_out();
    cyc(); rst_n = 1'b0;
    expect_out("rst_p_async", 2'b00, 64'h0, 1, 0, 0, 0, 0, 0, 0); check_out();
    cyc(); rst_n = 1'b1; clear_in();
    expect_out("rst_q_release", 2'b00, 64'h0, 0, 0, 0, 0, 0, 0, 0); check_out();
    cyc();
    expect_out("rst_r_nopulse", 2'b00, 64'h0, 0, 0, 0, 0, 0, 0, 0); check_out();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2, number of independent execute-stage source operands checked.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Parameter MISS_TIMEOUT, default 255, maximum MISS_WAIT cycles before abort; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 src_valid  input  NUM_SRC  per-source operand valid in execute.
REQ-007 src_reg  input  NUM_SRC*5  per-source register index, source i at bits [5i+4:5i].
REQ-008 valid_m, load_m  input  1 each  memory-stage instruction valid; it is a load.
REQ-009 dest_m, dest_w  input  5 each  destination register in memory / writeback.
REQ-010 data_m, data_w  input  XLEN each  result in memory / writeback.
REQ-011 valid_w  input  1  writeback-stage instruction valid.
REQ-012 mem_busy, mem_done  input  1 each  cache miss in progress; miss completes this cycle.
REQ-013 flush  input  1  execute-stage squash.
REQ-014 fwd  output  NUM_SRC  per-source forward select.
REQ-015 fwd_data  output  NUM_SRC*XLEN  per-source forwarded value, source i at [XLEN*i+XLEN-1:XLEN*i].
REQ-016 stall  output  1  hold fetch/decode/execute, bubble into memory.
REQ-017 miss_pend  output  1  registered, high while FSM is MISS_WAIT.
REQ-018 miss_timeout  output  1  registered one-cycle abort pulse.
REQ-019 ld_use_cnt, miss_cyc_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-020 Per source i, combinationally: active only if src_valid[i] and not flush; otherwise fwd[i]=0, data slice 0, no hazard contribution.
REQ-021 Active source matching dest_m (nonzero) with valid_m: fwd[i]=!load_m, data slice=data_m; load_m raises load-use hazard.
REQ-022 Else active source matching dest_w (nonzero) with valid_w: fwd[i]=1, data slice=data_w.
REQ-023 Else fwd[i]=0, data slice 0; register 0 never forwards or hazards.
REQ-024 Memory stage has priority over writeback; sources evaluated independently, no cross-source priority.
REQ-025 FSM states IDLE, MISS_WAIT; state register plus 16-bit wait counter.
REQ-026 IDLE->MISS_WAIT when valid_m, load_m and mem_busy and not mem_done; counter cleared to 0.
REQ-027 MISS_WAIT->IDLE on mem_done; counter cleared.
REQ-028 MISS_WAIT: counter increments each cycle without mem_done; counter reaching MISS_TIMEOUT without mem_done -> IDLE, miss_timeout pulses next cycle exactly once.
REQ-029 mem_done and timeout same cycle: mem_done wins, no pulse.
REQ-030 stall = any load-use hazard OR state==MISS_WAIT OR (IDLE and entry condition of REQ-026); combinational, zero-cycle latency.
REQ-031 In MISS_WAIT stall=1 irrespective of flush or src_valid; fwd/fwd_data still follow REQ-020..023.
REQ-032 flush does not change FSM state or counters.

Reset
REQ-033 rst_n low asynchronously forces IDLE, wait counter 0, miss_pend 0, miss_timeout 0, perf counters 0.
REQ-034 Reset mid-MISS_WAIT abandons the miss without a timeout pulse; combinational outputs follow inputs during reset.

Configuration
REQ-035 Macro HAZARD_PERF_EN defined: ld_use_cnt increments each cycle a load-use hazard holds stall; miss_cyc_cnt increments each MISS_WAIT cycle; both saturate at 0xFFFFFFFF.
REQ-036 HAZARD_PERF_EN undefined: no counter registers; ld_use_cnt and miss_cyc_cnt tied to 0; all other behaviour identical.

Verification
REQ-037 src_reg[0]=5 valid, valid_m=1, load_m=0, dest_m=5, data_m=0xAAAA0001, dest_w=5, data_w=0x1 -> fwd[0]=1, slice 0=0xAAAA0001, stall=0.
REQ-038 src_reg[1]=7, valid_m=1, load_m=1, dest_m=7, mem_busy=0 -> stall=1, fwd[1]=0; with HAZARD_PERF_EN ld_use_cnt 0->1 after edge.
REQ-039 Both sources reg 0, dest_m=dest_w=0, all valid -> fwd=0, data 0, stall=0.
REQ-040 Load in M, mem_busy=1 for 4 cycles then mem_done -> miss_pend high 4 cycles, stall high 5 cycles, IDLE after; miss_cyc_cnt=4.
REQ-041 MISS_TIMEOUT=3, mem_busy held, no mem_done -> return to IDLE after 4 MISS_WAIT cycles, miss_timeout high exactly one cycle.
REQ-042 rst_n low in MISS_WAIT cycle 2 -> miss_pend=0 immediately, no miss_timeout pulse, counters 0.
